// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizing: physical register tags and free-list pointers.
package rename_pkg;
    localparam int NUM_PREG = 64;
    localparam int PREG_W   = 6;
    localparam int FL_DEPTH = 32;
    localparam int IDX_W    = 5;

    typedef logic [PREG_W-1:0] preg_t;
    // Pointer = 5-bit list index plus a wrap bit, so full and empty are distinguishable.
    typedef logic [IDX_W:0]    ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/freelist_ram.sv
// 32x6 free-list storage: one synchronous write port, one asynchronous read port.
// Reset loads entry i with tag 32+i, the architecturally unmapped registers.
module freelist_ram
    import rename_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [PREG_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [PREG_W-1:0] rdata_o
);
    preg_t mem_q [FL_DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= preg_t'(FL_DEPTH + i);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rename_freelist_ctrl.sv
// Rename free-list controller: speculative/commit heads, tail, count and sticky error.
// Allocation is zero-latency (tag visible combinationally, head moves next edge); grant drops when empty or flushing.
module rename_freelist_ctrl
    import rename_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              alloc_req,
    output logic              alloc_grant,
    output logic [PREG_W-1:0] alloc_reg,
    input  logic              commit_valid,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_reg,
    input  logic              FLUSH,
    output logic [PREG_W-1:0] free_count,
    output logic              empty,
    output logic              err
);
    ptr_t  spec_head_q, spec_head_d;
    ptr_t  commit_head_q, commit_head_d;
    ptr_t  tail_q, tail_d;
    logic [PREG_W-1:0] free_count_q, free_count_d;
    logic  err_q, err_d;

    logic  full;
    logic  commit_ok;
    logic  free_ok;
    ptr_t  occupancy;

    always_comb begin
        occupancy   = tail_q - commit_head_q;
        full        = (occupancy == ptr_t'(FL_DEPTH));
        alloc_grant = alloc_req & ~empty & ~FLUSH & ~RESET;
        // A commit may never overtake the speculative head.
        commit_ok   = commit_valid & (commit_head_q != spec_head_q);
        free_ok     = free_valid & (free_reg != '0) & ~full;
        err_d       = err_q | (commit_valid & ~commit_ok) | (free_valid & ~free_ok);

        commit_head_d = commit_ok ? ptr_inc(commit_head_q) : commit_head_q;
        tail_d        = free_ok   ? ptr_inc(tail_q)        : tail_q;

        // Flush rewinds to the committed head including this cycle's retirement.
        if (FLUSH) begin
            spec_head_d = commit_head_d;
        end else if (alloc_grant) begin
            spec_head_d = ptr_inc(spec_head_q);
        end else begin
            spec_head_d = spec_head_q;
        end

        free_count_d = tail_d - spec_head_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= ptr_t'(FL_DEPTH);
            free_count_q  <= PREG_W'(FL_DEPTH);
            err_q         <= 1'b0;
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            free_count_q  <= free_count_d;
            err_q         <= err_d;
        end
    end

    freelist_ram u_ram (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (free_ok),
        .waddr_i (tail_q[IDX_W-1:0]),
        .wdata_i (free_reg),
        .raddr_i (spec_head_q[IDX_W-1:0]),
        .rdata_o (alloc_reg)
    );

    assign free_count = free_count_q;
    assign empty      = (free_count_q == '0);
    assign err        = err_q;
endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Bench for rename_freelist_ctrl: directed scenarios plus randomized traffic against an unbounded-counter model.
module tb_rename_freelist_ctrl;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       alloc_req, commit_valid, free_valid, FLUSH;
    logic [5:0] free_reg;
    logic       alloc_grant, empty, err;
    logic [5:0] alloc_reg, free_count;

    int errors = 0;
    int checks = 0;

    // Model: plain integer counters that never wrap; list index is count mod 32.
    int m_list [32];
    int m_spec, m_cmt, m_tail;
    bit m_err;

    rename_freelist_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_reg    (alloc_reg),
        .commit_valid (commit_valid),
        .free_valid   (free_valid),
        .free_reg     (free_reg),
        .FLUSH        (FLUSH),
        .free_count   (free_count),
        .empty        (empty),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_list[i] = 32 + i;
        m_spec = 0;
        m_cmt  = 0;
        m_tail = 32;
        m_err  = 0;
    endfunction

    task automatic compare();
        int cnt;
        bit g;
        cnt = m_tail - m_spec;
        g   = alloc_req && (cnt != 0) && !FLUSH;
        chk("alloc_grant", alloc_grant, g);
        chk("alloc_reg", alloc_reg, m_list[m_spec % 32]);
        chk("free_count", free_count, cnt);
        chk("empty", empty, cnt == 0);
        chk("err", err, m_err);
    endtask

    task automatic m_update();
        bit g, cok, fok;
        g   = alloc_req && (m_tail != m_spec) && !FLUSH;
        cok = commit_valid && (m_cmt != m_spec);
        fok = free_valid && (free_reg != 0) && ((m_tail - m_cmt) < 32);
        if (commit_valid && !cok) m_err = 1;
        if (free_valid && !fok)   m_err = 1;
        if (fok) begin
            m_list[m_tail % 32] = free_reg;
            m_tail++;
        end
        if (cok) m_cmt++;
        if (FLUSH)  m_spec = m_cmt;
        else if (g) m_spec++;
    endtask

    task automatic drive(input bit ar, input bit cv, input bit fv, input int fr, input bit fl);
        alloc_req    = ar;
        commit_valid = cv;
        free_valid   = fv;
        free_reg     = 6'(fr);
        FLUSH        = fl;
        #1 compare();
    endtask

    task automatic tick();
        @(posedge CLK);
        m_update();
        @(negedge CLK);
    endtask

    task automatic cyc(input bit ar, input bit cv, input bit fv, input int fr, input bit fl);
        drive(ar, cv, fv, fr, fl);
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_grant"}, alloc_grant, 0);
        chk({tag, "_count"}, free_count, 32);
        chk({tag, "_empty"}, empty, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_reg"}, alloc_reg, 32);
    endtask

    task automatic do_reset();
        alloc_req = 0; commit_valid = 0; free_valid = 0; free_reg = 0; FLUSH = 0;
        RESET = 1;
        #1 reset_vals("rst");
        @(posedge CLK);
        @(negedge CLK);
        RESET = 0;
        m_reset();
    endtask

    initial begin
        m_reset();
        do_reset();

        // Reset then allocate three.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            chk("seq_reg", alloc_reg, 32 + i);
            chk("seq_grant", alloc_grant, 1);
            tick();
        end
        idle();
        chk("seq_count", free_count, 29);

        // Drain to empty.
        for (int i = 0; i < 29; i++) cyc(1, 0, 0, 0, 0);
        idle();
        chk("drain_empty", empty, 1);
        chk("drain_count", free_count, 0);
        drive(1, 0, 0, 0, 0);
        chk("drain_33_grant", alloc_grant, 0);
        tick();
        idle();
        chk("drain_head_held", alloc_reg, 32);

        // Free into empty list with a same-cycle alloc.
        cyc(0, 1, 0, 0, 0);
        drive(1, 0, 1, 7, 0);
        chk("free_empty_grant", alloc_grant, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        chk("free_next_reg", alloc_reg, 7);
        chk("free_next_grant", alloc_grant, 1);
        tick();
        idle();
        chk("free_after_count", free_count, 0);

        // Flush recovery.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 1);
        chk("flush_grant", alloc_grant, 0);
        tick();
        idle();
        chk("flush_count", free_count, 29);
        chk("flush_reg", alloc_reg, 35);

        // Error: free while full.
        do_reset();
        cyc(0, 0, 1, 9, 0);
        idle();
        chk("err_full", err, 1);
        chk("err_full_reg", alloc_reg, 32);
        chk("err_full_count", free_count, 32);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        idle();
        chk("err_sticky", err, 1);

        // Error: free of p0.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle();
        chk("err_p0", err, 1);
        chk("err_p0_reg", alloc_reg, 33);
        chk("err_p0_count", free_count, 31);

        // Error: commit with nothing speculative.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        idle();
        chk("err_commit", err, 1);
        chk("err_commit_reg", alloc_reg, 32);

        // Mid-stream reset between edges.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        alloc_req = 1;
        #3 RESET = 1;
        #1 reset_vals("mid_rst");
        alloc_req = 0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 0;
        m_reset();
        idle();

        // Randomized legal traffic.
        for (int n = 0; n < 3000; n++) begin
            bit ar, cv, fv, fl;
            ar = $urandom_range(0, 99) < 60;
            cv = (m_spec > m_cmt) && ($urandom_range(0, 99) < 55);
            fv = ((m_tail - m_cmt) < 32) && ($urandom_range(0, 99) < 60);
            fl = $urandom_range(0, 99) < 3;
            cyc(ar, cv, fv, $urandom_range(1, 63), fl);
        end

        // Randomized traffic including protocol violations.
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 63), $urandom_range(0, 99) < 5);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
